// File: rtl/pe_stream.sv
// pe_stream: streaming radix-2 butterfly PE, 3-stage pipeline with valid/ready.
// S1 add/sub + twiddle/flag capture, S2 multiply/accumulate, S3 round/select
// into the output registers. Define PE_SAT_EN for saturating sums and products;
// without it all WIDTH-bit results wrap.
module pe_stream #(
  parameter int WIDTH    = 32,
  parameter int TF_WIDTH = 32,
  parameter int SHIFT    = 16,
  parameter int ROUND    = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in0,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  input  logic [WIDTH-1:0]      in3,
  input  logic [2*TF_WIDTH-1:0] tf,
  input  logic                  bypass_n,
  input  logic                  inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out0,
  output logic [WIDTH-1:0]      out1,
  output logic [WIDTH-1:0]      out2,
  output logic [WIDTH-1:0]      out3
);

  // Two guard bits: one for the sum of two products, one for the negated twiddle.
  localparam int AW = WIDTH + TF_WIDTH + 2;
  localparam logic [AW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (AW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

`ifdef PE_SAT_EN
  function automatic logic [WIDTH-1:0] clamp_add(input logic [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1])
      clamp_add = x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      clamp_add = x[WIDTH-1:0];
  endfunction
`endif

  function automatic logic [WIDTH-1:0] sel_prod(input logic [AW-1:0] p);
    logic [AW-1:0] t;
    t = p + RND;
`ifdef PE_SAT_EN
    if (!(&t[AW-1:SHIFT+WIDTH-1]) && (|t[AW-1:SHIFT+WIDTH-1]))
      sel_prod = t[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sel_prod = t[SHIFT+WIDTH-1:SHIFT];
`else
    sel_prod = t[SHIFT+WIDTH-1:SHIFT];
`endif
  endfunction

  logic w_stall, w_en;
  logic signed [WIDTH-1:0]  w_s0, w_d1, w_s2, w_d3;
  logic signed [TF_WIDTH:0] w_ti;
  logic signed [AW-1:0]     w_p2, w_p3;

  logic                       r_v1, r_rot1;
  logic signed [WIDTH-1:0]    r_s0, r_d1, r_s2, r_d3;
  logic signed [TF_WIDTH-1:0] r_tr;
  logic signed [TF_WIDTH:0]   r_ti;

  logic                    r_v2, r_rot2;
  logic signed [WIDTH-1:0] r_s0_2, r_s2_2, r_d1_2, r_d3_2;
  logic signed [AW-1:0]    r_p2, r_p3;

  logic             r_ov;
  logic [WIDTH-1:0] r_o0, r_o1, r_o2, r_o3;

  assign w_stall   = r_ov & ~out_ready;
  assign w_en      = ~w_stall;
  assign in_ready  = ~Reset & ~w_stall;
  assign out_valid = r_ov;
  assign out0      = r_o0;
  assign out1      = r_o1;
  assign out2      = r_o2;
  assign out3      = r_o3;

  // S1 combinational: butterfly sums/differences and conditionally conjugated twiddle.
  always_comb begin
`ifdef PE_SAT_EN
    w_s0 = clamp_add({in0[WIDTH-1], in0} + {in1[WIDTH-1], in1});
    w_d1 = clamp_add({in0[WIDTH-1], in0} - {in1[WIDTH-1], in1});
    w_s2 = clamp_add({in2[WIDTH-1], in2} + {in3[WIDTH-1], in3});
    w_d3 = clamp_add({in2[WIDTH-1], in2} - {in3[WIDTH-1], in3});
`else
    w_s0 = in0 + in1;
    w_d1 = in0 - in1;
    w_s2 = in2 + in3;
    w_d3 = in2 - in3;
`endif
    // Extra bit keeps -(most negative twiddle) representable.
    w_ti = inv ? -{tf[TF_WIDTH-1], tf[TF_WIDTH-1:0]} : {tf[TF_WIDTH-1], tf[TF_WIDTH-1:0]};
  end

  // S2 combinational: complex rotation of the difference pair.
  always_comb begin
    w_p2 = AW'(r_d1) * AW'(r_tr) - AW'(r_d3) * AW'(r_ti);
    w_p3 = -(AW'(r_d1) * AW'(r_ti) + AW'(r_d3) * AW'(r_tr));
  end

  // S1 register: sums, differences, twiddle and per-beat mode.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_v1 <= 1'b0;
      r_rot1 <= 1'b0;
      r_s0 <= '0; r_d1 <= '0; r_s2 <= '0; r_d3 <= '0;
      r_tr <= '0; r_ti <= '0;
    end else if (w_en) begin
      r_v1   <= in_valid;
      r_rot1 <= bypass_n;
      r_s0 <= w_s0; r_d1 <= w_d1; r_s2 <= w_s2; r_d3 <= w_d3;
      r_tr <= tf[2*TF_WIDTH-1:TF_WIDTH];
      r_ti <= w_ti;
    end
  end

  // S2 register: products plus delayed sums and unrotated differences.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_v2 <= 1'b0;
      r_rot2 <= 1'b0;
      r_s0_2 <= '0; r_s2_2 <= '0; r_d1_2 <= '0; r_d3_2 <= '0;
      r_p2 <= '0; r_p3 <= '0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_rot2 <= r_rot1;
      r_s0_2 <= r_s0; r_s2_2 <= r_s2; r_d1_2 <= r_d1; r_d3_2 <= r_d3;
      r_p2 <= w_p2; r_p3 <= w_p3;
    end
  end

  // S3 register: output data loads only with a valid beat; valid advances with the pipe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ov <= 1'b0;
      r_o0 <= '0; r_o1 <= '0; r_o2 <= '0; r_o3 <= '0;
    end else if (w_en) begin
      r_ov <= r_v2;
      if (r_v2) begin
        r_o0 <= r_s0_2;
        r_o1 <= r_s2_2;
        r_o2 <= r_rot2 ? sel_prod(r_p2) : r_d1_2;
        r_o3 <= r_rot2 ? sel_prod(r_p3) : r_d3_2;
      end
    end
  end

endmodule

// File: tb/tb_pe_stream.sv
// Testbench for pe_stream: directed steps with a scoreboard, default build and a
// second instance with ROUND=1 fed the same stream. Honours PE_SAT_EN.
module tb_pe_stream;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [63:0] tf = '0;
  logic        bypass_n = 1'b1, inv = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out0, out1, out2, out3;
  logic        r_in_ready, r_out_valid;
  logic [31:0] r_out0, r_out1, r_out2, r_out3;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] q_main[$];
  logic [127:0] q_rnd[$];
  logic [31:0]  snap[4];

  always #5 Clk = ~Clk;

  pe_stream #(.WIDTH(32), .TF_WIDTH(32), .SHIFT(16), .ROUND(0)) u_dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .tf(tf),
    .bypass_n(bypass_n), .inv(inv), .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3));

  pe_stream #(.WIDTH(32), .TF_WIDTH(32), .SHIFT(16), .ROUND(1)) u_rnd (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(r_in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .tf(tf),
    .bypass_n(bypass_n), .inv(inv), .out_valid(r_out_valid), .out_ready(out_ready),
    .out0(r_out0), .out1(r_out1), .out2(r_out2), .out3(r_out3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fit(input logic signed [127:0] v);
`ifdef PE_SAT_EN
    if (v > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (v < -128'sh80000000) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  function automatic logic [127:0] model(input logic signed [31:0] a, b, c, d,
                                         input logic [63:0] t, input logic byp, iv,
                                         input bit rnd);
    logic signed [127:0] s0, d1, s2, d3, tr, ti, p2, p3;
    logic [31:0] o0, o1, o2, o3, dd1, dd3;
    s0 = a; s0 = s0 + b;
    d1 = a; d1 = d1 - b;
    s2 = c; s2 = s2 + d;
    d3 = c; d3 = d3 - d;
    o0 = fit(s0); o1 = fit(s2);
    dd1 = fit(d1); dd3 = fit(d3);
    d1 = $signed(dd1); d3 = $signed(dd3);
    tr = $signed(t[63:32]);
    ti = $signed(t[31:0]);
    if (iv) ti = -ti;
    p2 = d1 * tr - d3 * ti;
    p3 = -(d1 * ti + d3 * tr);
    if (rnd) begin
      p2 = p2 + 128'sd32768;
      p3 = p3 + 128'sd32768;
    end
    o2 = byp ? fit(p2 >>> 16) : dd1;
    o3 = byp ? fit(p3 >>> 16) : dd3;
    return {o0, o1, o2, o3};
  endfunction

  // Drives one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] a, b, c, d, input logic [63:0] t,
                      input logic byp, iv);
    int guard;
    guard = 0;
    in0 = a; in1 = b; in2 = c; in3 = d; tf = t; bypass_n = byp; inv = iv;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge Clk); #1;
      guard++;
    end
    if (!in_ready) check("send_ready", {31'b0, in_ready}, 32'd1);
    else begin
      q_main.push_back(model(a, b, c, d, t, byp, iv, 1'b0));
      q_rnd.push_back(model(a, b, c, d, t, byp, iv, 1'b1));
    end
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q_main.size() != 0 && g < 100) begin
      @(negedge Clk);
      g++;
    end
    check("drain", q_main.size(), 32'd0);
  endtask

  // Scoreboard: compare every transfer against the oldest expected beat.
  always @(negedge Clk) begin
    logic [127:0] e;
    #2;
    if (!Reset && out_valid && out_ready) begin
      if (q_main.size() == 0) check("unexpected_out", {31'b0, out_valid}, 32'd0);
      else begin
        e = q_main.pop_front();
        check("out0", out0, e[127:96]);
        check("out1", out1, e[95:64]);
        check("out2", out2, e[63:32]);
        check("out3", out3, e[31:0]);
      end
      if (q_rnd.size() != 0) begin
        e = q_rnd.pop_front();
        check("rnd_out2", r_out2, e[63:32]);
        check("rnd_out3", r_out3, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out0", out0, 32'd0);
    check("rst_out3", out3, 32'd0);
    Reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Forward rotation with latency check
    @(negedge Clk);
    in0 = 32'd5; in1 = 32'd3; in2 = 32'd7; in3 = 32'd2;
    tf = {32'd65536, 32'd0}; bypass_n = 1'b1; inv = 1'b0; in_valid = 1'b1;
    q_main.push_back(model(5, 3, 7, 2, {32'd65536, 32'd0}, 1'b1, 1'b0, 1'b0));
    q_rnd.push_back(model(5, 3, 7, 2, {32'd65536, 32'd0}, 1'b1, 1'b0, 1'b1));
    #1;
    check("fwd_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    check("lat_edge1", {31'b0, out_valid}, 32'd0);
    @(posedge Clk); #1;
    check("lat_edge2", {31'b0, out_valid}, 32'd0);
    @(posedge Clk); #1;
    check("lat_edge3", {31'b0, out_valid}, 32'd1);
    check("fwd_out0", out0, 32'd8);
    check("fwd_out1", out1, 32'd9);
    check("fwd_out2", out2, 32'd2);
    check("fwd_out3", out3, 32'hFFFF_FFFB);
    @(negedge Clk);
    drain();

    // Inverse vs forward, interleaved per beat, back-to-back
    send(5, 3, 7, 2, {32'd0, 32'd65536}, 1'b1, 1'b0);
    send(5, 3, 7, 2, {32'd0, 32'd65536}, 1'b1, 1'b1);
    send(5, 3, 7, 2, {32'd0, 32'd65536}, 1'b1, 1'b0);
    send(5, 3, 7, 2, {32'd0, 32'd65536}, 1'b1, 1'b1);
    // Bypass ignores the twiddle
    send(5, 3, 7, 2, {32'h1234_5678, 32'h9ABC_DEF0}, 1'b0, 1'b0);
    send(5, 3, 7, 2, {32'hDEAD_BEEF, 32'h8000_0000}, 1'b0, 1'b1);
    // Rounding (ROUND=1 instance gives 1, default gives 0)
    send(1, 0, 0, 0, {32'd32768, 32'd0}, 1'b1, 1'b0);
    // Saturation / wrap boundaries
    send(32'h7FFF_FFFF, 1, 32'h8000_0000, 1, {32'd65536, 32'd0}, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
         {32'h7FFF_FFFF, 32'h8000_0000}, 1'b1, 1'b1);
    drain();

    // Backpressure: 6 beats, out_ready low for 4 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++)
          send($urandom, $urandom, $urandom, $urandom, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(negedge Clk);
        out_ready = 1'b0;
        #1;
        check("stall_out_valid", {31'b0, out_valid}, 32'd1);
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        snap[0] = out0; snap[1] = out1; snap[2] = out2; snap[3] = out3;
        for (int k = 0; k < 3; k++) begin
          @(negedge Clk); #1;
          check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
          check("stall_hold_ready", {31'b0, in_ready}, 32'd0);
          check("stall_hold_out0", out0, snap[0]);
          check("stall_hold_out1", out1, snap[1]);
          check("stall_hold_out2", out2, snap[2]);
          check("stall_hold_out3", out3, snap[3]);
        end
        @(negedge Clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 20; i++)
          send($urandom, $urandom, $urandom, $urandom, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge Clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge Clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with 3 beats in flight
    out_ready = 1'b0;
    send(11, 1, 2, 3, {32'd65536, 32'd0}, 1'b1, 1'b0);
    send(12, 1, 2, 3, {32'd65536, 32'd0}, 1'b1, 1'b0);
    send(13, 1, 2, 3, {32'd65536, 32'd0}, 1'b1, 1'b0);
    Reset = 1'b1;
    q_main.delete();
    q_rnd.delete();
    @(posedge Clk); #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_out0", out0, 32'd0);
    check("midrst_out1", out1, 32'd0);
    check("midrst_out2", out2, 32'd0);
    check("midrst_out3", out3, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("after_rst_out_valid", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk); #1;
      check("no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
